mem_fill_responder: RTL and testbench

//  Backing-memory responder on the memory side of the L2 cache. Services line fill (read)
//  and line writeback (write) requests issued on a miss/eviction. Reads return a burst of

---
 rtl/mem_fill_responder_if.sv | 30 +++
 rtl/mem_fill_responder.sv | 178 +++++++++++++++++
 tb/tb_mem_fill_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_fill_responder_if.sv
// Request / writeback / fill channels between the L2 cache (master) and the
// backing-memory responder (slave).
interface mem_fill_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_last;
    logic              wr_done;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, wdata_valid, wdata, resp_ready,
        input  req_ready, wdata_ready, resp_valid, resp_data, resp_last, wr_done, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, wdata_valid, wdata, resp_ready,
        output req_ready, wdata_ready, resp_valid, resp_data, resp_last, wr_done, busy
    );
endinterface

// File: rtl/mem_fill_responder.sv
// Backing memory behind the L2: serves one line fill or line writeback at a
// time, with a fixed access latency and BLOCK_WORDS-beat bursts.
module mem_fill_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int MEM_WORDS   = 1024,
    parameter int LATENCY     = 8,
    parameter int INIT_PAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_fill_responder_if.slave io_bus
);
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int BEAT_W  = $clog2(BLOCK_WORDS);
    localparam int IDX_W   = $clog2(MEM_WORDS);
    localparam int LINE_W  = IDX_W - BEAT_W;
    localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_BURST,
        S_WR_BURST,
        S_WR_WAIT
    } state_t;

    state_t              r_state;
    logic [LINE_W-1:0]   r_line;
    logic [BEAT_W-1:0]   r_beat;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_req_ready;
    logic                r_wdata_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_resp_last;
    logic                r_wr_done;
    logic                r_busy;
    logic [DATA_W-1:0]   r_mem [MEM_WORDS];

    logic [LINE_W-1:0]   w_req_line;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [IDX_W-1:0]    w_idx_first;
    logic [IDX_W-1:0]    w_idx_next;
    logic [IDX_W-1:0]    w_idx_cur;
    logic [DATA_W-1:0]   w_rd_first;
    logic [DATA_W-1:0]   w_rd_next;
    logic                w_req_fire;
    logic                w_resp_fire;
    logic                w_wbeat_fire;
    logic                w_last_beat;
    logic                w_unused_addr;

    // Words are stored XOR-ed with their init pattern, so a zero power-up
    // array reads back as mem[i]=i without any initialisation logic.
    function automatic logic [DATA_W-1:0] init_word(input logic [IDX_W-1:0] idx);
        if (INIT_PAT != 0) return DATA_W'(idx);
        return '0;
    endfunction

    // The line index is the word address with the beat bits dropped; upper
    // address bits fall off, giving the intended wrap-around aliasing.
    assign w_req_line    = io_bus.req_addr[BYTE_SH + BEAT_W +: LINE_W];
    assign w_unused_addr = ^io_bus.req_addr;
    assign w_beat_nxt    = r_beat + BEAT_W'(1);
    assign w_idx_first   = {r_line, {BEAT_W{1'b0}}};
    assign w_idx_next    = {r_line, w_beat_nxt};
    assign w_idx_cur     = {r_line, r_beat};
    assign w_rd_first    = r_mem[w_idx_first] ^ init_word(w_idx_first);
    assign w_rd_next     = r_mem[w_idx_next] ^ init_word(w_idx_next);

    assign w_req_fire    = io_bus.req_valid && r_req_ready;
    assign w_resp_fire   = r_resp_valid && io_bus.resp_ready;
    assign w_wbeat_fire  = r_wdata_ready && io_bus.wdata_valid;
    assign w_last_beat   = (r_beat == BEAT_W'(BLOCK_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst && w_wbeat_fire) begin
            r_mem[w_idx_cur] <= io_bus.wdata ^ init_word(w_idx_cur);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_line        <= '0;
            r_beat        <= '0;
            r_cnt         <= '0;
            r_req_ready   <= 1'b0;
            r_wdata_ready <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_resp_last   <= 1'b0;
            r_wr_done     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    if (w_req_fire) begin
                        r_line      <= w_req_line;
                        r_beat      <= '0;
                        r_cnt       <= CNT_W'(LATENCY - 1);
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (io_bus.req_write) begin
                            r_state       <= S_WR_BURST;
                            r_wdata_ready <= 1'b1;
                        end else begin
                            r_state <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state      <= S_RD_BURST;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_rd_first;
                        r_resp_last  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                // A stalled beat simply holds data/last until the cache takes it.
                S_RD_BURST: begin
                    if (w_resp_fire) begin
                        if (w_last_beat) begin
                            r_state      <= S_IDLE;
                            r_resp_valid <= 1'b0;
                            r_resp_last  <= 1'b0;
                            r_req_ready  <= 1'b1;
                            r_busy       <= 1'b0;
                            r_beat       <= '0;
                        end else begin
                            r_beat      <= w_beat_nxt;
                            r_resp_data <= w_rd_next;
                            r_resp_last <= (w_beat_nxt == BEAT_W'(BLOCK_WORDS - 1));
                        end
                    end
                end
                S_WR_BURST: begin
                    if (w_wbeat_fire) begin
                        if (w_last_beat) begin
                            r_state       <= S_WR_WAIT;
                            r_wdata_ready <= 1'b0;
                            r_cnt         <= CNT_W'(LATENCY - 1);
                            r_beat        <= '0;
                        end else begin
                            r_beat <= w_beat_nxt;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_IDLE;
                        r_wr_done   <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.req_ready   = r_req_ready;
    assign io_bus.wdata_ready = r_wdata_ready;
    assign io_bus.resp_valid  = r_resp_valid;
    assign io_bus.resp_data   = r_resp_data;
    assign io_bus.resp_last   = r_resp_last;
    assign io_bus.wr_done     = r_wr_done;
    assign io_bus.busy        = r_busy;
endmodule

// File: tb/tb_mem_fill_responder.sv
// Randomised bench for mem_fill_responder against a word-array model of the
// backing memory.
module tb_mem_fill_responder;
    localparam int LAT = 8;
    localparam int BW  = 4;
    localparam int MW  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_fill_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_fill_responder #(
        .ADDR_W(32), .DATA_W(32), .BLOCK_WORDS(BW), .MEM_WORDS(MW),
        .LATENCY(LAT), .INIT_PAT(1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_accept = 0;
    logic [31:0] ref_mem [MW];

    always @(posedge clk) begin
        if (!rst && bus.req_valid === 1'b1 && bus.req_ready === 1'b1) n_accept <= n_accept + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned line_base(input logic [31:0] addr);
        return ((addr >> 2) & ~32'(BW - 1)) % MW;
    endfunction

    task automatic idle_inputs();
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.resp_ready  = 1'b0;
    endtask

    task automatic wait_req_ready(output bit ok);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        ok = (bus.req_ready === 1'b1);
        n_checks++;
        if (!ok) $display("FAIL req_ready_wait: req_ready=%b after %0d cycles, want 1", bus.req_ready, n);
        else n_pass++;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
    task automatic run_fill(input logic [31:0] addr, input int mode, input bit hold_next,
                            input logic [31:0] next_addr);
        bit ok, rdy;
        int lat, beat, cyc;
        int unsigned base;
        base = line_base(addr);
        wait_req_ready(ok);
        if (!ok) return;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = addr;
        step();
        if (hold_next) begin
            bus.req_addr = next_addr;
        end else begin
            bus.req_valid = 1'b0;
            bus.req_write = 1'($urandom);
            bus.req_addr  = $urandom;
        end
        n_checks++;
        if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0)
            $display("FAIL fill_accept: busy=%b req_ready=%b, want busy=1 req_ready=0", bus.busy, bus.req_ready);
        else n_pass++;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 40) begin
            bus.resp_ready = 1'($urandom);
            step();
            lat++;
        end
        n_checks++;
        if (lat !== LAT) $display("FAIL fill_latency: resp_valid after %0d cycles, want %0d", lat, LAT);
        else n_pass++;
        beat = 0;
        cyc  = 0;
        while (beat < BW && cyc < 200) begin
            n_checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== ref_mem[base + beat] ||
                bus.resp_last !== 1'(beat == BW - 1))
                $display("FAIL fill_beat%0d @%h: valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                         beat, addr, bus.resp_valid, bus.resp_data, bus.resp_last,
                         ref_mem[base + beat], (beat == BW - 1));
            else n_pass++;
            if (hold_next) begin
                n_checks++;
                if (bus.req_ready !== 1'b0) $display("FAIL busy_req_ready: req_ready=%b during burst, want 0", bus.req_ready);
                else n_pass++;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.resp_ready = rdy;
            step();
            if (rdy) beat++;
            cyc++;
        end
        bus.resp_ready = 1'b0;
        n_checks++;
        if (beat != BW || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL fill_end: beats=%0d resp_valid=%b req_ready=%b busy=%b, want %0d/0/1/0",
                     beat, bus.resp_valid, bus.req_ready, bus.busy, BW);
        else n_pass++;
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [BW*32-1:0] dpk, input bit gaps);
        bit ok, v;
        int lat, beat, cyc;
        int unsigned base;
        base = line_base(addr);
        wait_req_ready(ok);
        if (!ok) return;
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b1;
        bus.req_addr    = addr;
        bus.wdata_valid = 1'b1;
        bus.wdata       = $urandom;
        step();
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
        n_checks++;
        if (bus.wdata_ready !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL wr_accept: wdata_ready=%b busy=%b, want 1/1", bus.wdata_ready, bus.busy);
        else n_pass++;
        beat = 0;
        cyc  = 0;
        while (beat < BW && cyc < 200) begin
            n_checks++;
            if (bus.wdata_ready !== 1'b1) $display("FAIL wr_ready_beat%0d: wdata_ready=%b, want 1", beat, bus.wdata_ready);
            else n_pass++;
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wdata_valid = v;
            bus.wdata       = v ? dpk[beat*32 +: 32] : $urandom;
            step();
            if (v) begin
                ref_mem[base + beat] = dpk[beat*32 +: 32];
                beat++;
            end
            cyc++;
        end
        bus.wdata_valid = 1'b1;
        bus.wdata       = $urandom;
        n_checks++;
        if (bus.wdata_ready !== 1'b0) $display("FAIL wr_ready_end: wdata_ready=%b, want 0", bus.wdata_ready);
        else n_pass++;
        lat = 0;
        while (bus.wr_done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat !== LAT) $display("FAIL wr_done_latency: wr_done after %0d cycles, want %0d", lat, LAT);
        else n_pass++;
        step();
        bus.wdata_valid = 1'b0;
        n_checks++;
        if (bus.wr_done !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL wr_done_pulse: wr_done=%b req_ready=%b busy=%b, want 0/1/0",
                     bus.wr_done, bus.req_ready, bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = $urandom;
        bus.resp_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.req_ready !== 1'b0 || bus.wdata_ready !== 1'b0 || bus.resp_valid !== 1'b0 ||
            bus.resp_last !== 1'b0 || bus.wr_done !== 1'b0 || bus.busy !== 1'b0 || bus.resp_data !== 32'h0)
            $display("FAIL reset_outputs: rr=%b wr=%b rv=%b rl=%b wd=%b busy=%b data=%h, want all 0",
                     bus.req_ready, bus.wdata_ready, bus.resp_valid, bus.resp_last,
                     bus.wr_done, bus.busy, bus.resp_data);
        else n_pass++;
        idle_inputs();
        rst = 1'b0;
        step();
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL reset_release: req_ready=%b busy=%b, want 1/0", bus.req_ready, bus.busy);
        else n_pass++;
    endtask

    task automatic test_fill_basic();
        run_fill(32'h40, 0, 1'b0, 32'h0);
    endtask

    task automatic test_write_then_fill();
        run_write(32'h80, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
        run_fill(32'h8C, 0, 1'b0, 32'h0);
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        a = $urandom;
        run_write(a, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        run_fill({a[31:4], 4'($urandom)}, 1, 1'b0, 32'h0);
        run_fill($urandom, 1, 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        run_write(32'h1000, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);
        run_fill(32'h0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        int n0;
        a  = $urandom;
        b  = $urandom;
        n0 = n_accept;
        run_fill(a, 2, 1'b1, b);
        run_fill(b, 2, 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) step();
        n_checks++;
        if (n_accept - n0 != 2 || bus.busy !== 1'b0 || bus.resp_valid !== 1'b0)
            $display("FAIL back_to_back: accepts=%0d busy=%b resp_valid=%b, want 2/0/0",
                     n_accept - n0, bus.busy, bus.resp_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int lat;
        int unsigned base;
        logic [31:0] a;
        a    = $urandom;
        base = line_base(a);
        wait_req_ready(ok);
        if (!ok) return;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        step();
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        step();
        step();
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== ref_mem[base + 2])
            $display("FAIL rst_mid_beat2: valid=%b data=%h, want 1/%h", bus.resp_valid, bus.resp_data, ref_mem[base + 2]);
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.resp_last !== 1'b0 || bus.resp_data !== 32'h0)
            $display("FAIL rst_mid_abort: valid=%b busy=%b last=%b data=%h, want 0/0/0/0",
                     bus.resp_valid, bus.busy, bus.resp_last, bus.resp_data);
        else n_pass++;
        rst = 1'b0;
        bus.resp_ready = 1'b0;
        step();
        run_fill($urandom, 0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_write();
        bit ok, seen;
        int unsigned base;
        logic [31:0] a;
        a    = $urandom;
        base = line_base(a);
        wait_req_ready(ok);
        if (!ok) return;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = a;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = $urandom;
            ref_mem[base + i] = bus.wdata;
            step();
        end
        bus.wdata_valid = 1'b0;
        rst = 1'b1;
        step();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            if (bus.wr_done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL rst_mid_write: wr_done/busy seen after abort, want none");
        else n_pass++;
        run_fill(a, 2, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1)
                run_write($urandom, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
            else
                run_fill($urandom, int'($urandom_range(0, 2)), 1'b0, 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < MW; i++) ref_mem[i] = 32'(i);
        idle_inputs();
        test_reset();
        test_fill_basic();
        test_write_then_fill();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_mid_burst();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
